// File: rtl/custom_axi_ip_pkg.sv
// Shared types for custom_axi_ip and its AXI4-Lite register block:
// core state encoding, register offsets, AXI response codes, STATUS layout.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  localparam int unsigned CTRL_OFFS     = 32'h00;
  localparam int unsigned DATA_IN_OFFS  = 32'h04;
  localparam int unsigned DATA_OUT_OFFS = 32'h08;
  localparam int unsigned STATUS_OFFS   = 32'h0C;
  localparam int unsigned ID_OFFS       = 32'h10;

  localparam int unsigned STAT_DONE_BIT = 2;
  localparam int unsigned STAT_REJ_BIT  = 3;
  localparam int unsigned STAT_EN_BIT   = 4;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_DATA_IN, SEL_DATA_OUT, SEL_STATUS, SEL_ID, SEL_NONE
  } reg_sel_e;

  // Word-granular decode; the two low address bits never matter.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    logic [29:0] w;
    w = addr[31:2];
    if (w == 30'(CTRL_OFFS >> 2))          return SEL_CTRL;
    else if (w == 30'(DATA_IN_OFFS >> 2))  return SEL_DATA_IN;
    else if (w == 30'(DATA_OUT_OFFS >> 2)) return SEL_DATA_OUT;
    else if (w == 30'(STATUS_OFFS >> 2))   return SEL_STATUS;
    else if (w == 30'(ID_OFFS >> 2))       return SEL_ID;
    else                                   return SEL_NONE;
  endfunction

endpackage

// File: rtl/custom_axi_regs.sv
// AXI4-Lite register window onto custom_axi_ip: DATA_IN/CTRL towards the core,
// result/status back to the bus. AW and W are buffered independently.
module custom_axi_regs
  import custom_axi_ip_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hC0A1_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                    enable_o,
  input  logic [DATA_WIDTH-1:0]   ipreg_data_out_i,
  input  logic                    enable_i,
  input  logic [1:0]              status_i
);

  logic                    live;
  logic                    aw_full, w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    done_stky, rej_stky;

  reg_sel_e                wr_sel, rd_sel;
  logic                    commit, start_req, core_idle;
  logic                    done_clr, rej_clr, rej_set;
  logic [DATA_WIDTH-1:0]   rd_val, status_word;
  axi_resp_e               rd_resp, wr_resp;

  // Readies stay low through reset and rise one cycle after release.
  assign s_axi_awready = live && !aw_full;
  assign s_axi_wready  = live && !w_full;
  assign s_axi_arready = live && !s_axi_rvalid;

  assign commit    = aw_full && w_full && !s_axi_bvalid;
  assign wr_sel    = decode_addr(32'(aw_addr_q));
  assign rd_sel    = decode_addr(32'(s_axi_araddr));
  assign core_idle = (status_e'(status_i) == IDLE);
  assign start_req = commit && wr_sel == SEL_CTRL && w_strb_q[0] && w_data_q[0];
  assign rej_set   = start_req && !core_idle;
  assign done_clr  = commit && wr_sel == SEL_STATUS && w_strb_q[0] && w_data_q[STAT_DONE_BIT];
  assign rej_clr   = commit && wr_sel == SEL_STATUS && w_strb_q[0] && w_data_q[STAT_REJ_BIT];

  assign wr_resp = (wr_sel == SEL_CTRL || wr_sel == SEL_DATA_IN || wr_sel == SEL_STATUS)
                   ? OKAY : SLVERR;

  always_comb begin
    status_word = '0;
    status_word[1:0]           = status_i;
    status_word[STAT_DONE_BIT] = done_stky;
    status_word[STAT_REJ_BIT]  = rej_stky;
    status_word[STAT_EN_BIT]   = enable_i;
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = OKAY;
    unique case (rd_sel)
      SEL_CTRL:     rd_val = '0;
      SEL_DATA_IN:  rd_val = ipreg_data_o;
      SEL_DATA_OUT: rd_val = ipreg_data_out_i;
      SEL_STATUS:   rd_val = status_word;
      SEL_ID:       rd_val = DATA_WIDTH'(ID_VALUE);
      default:      rd_resp = SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      live         <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= '0;
      s_axi_rdata  <= '0;
      ipreg_data_o <= '0;
      enable_o     <= 1'b0;
      done_stky    <= 1'b0;
      rej_stky     <= 1'b0;
    end else begin
      live     <= 1'b1;
      enable_o <= start_req && core_idle;

      if (s_axi_awvalid && s_axi_awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end

      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;

      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
        if (wr_sel == SEL_DATA_IN)
          for (int b = 0; b < DATA_WIDTH/8; b++)
            if (w_strb_q[b]) ipreg_data_o[8*b +: 8] <= w_data_q[8*b +: 8];
      end

      // Hardware set wins over a simultaneous software clear.
      done_stky <= (status_e'(status_i) == DONE) || (done_stky && !done_clr);
      rej_stky  <= rej_set || (rej_stky && !rej_clr);

      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_custom_axi_regs.sv
// Directed bench for custom_axi_regs: one task per scenario, inline checks.
module tb_custom_axi_regs;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ipreg_data_o, ipreg_data_out_i;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, status_i;
  logic        enable_o, enable_i;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (enable_o === 1'b1) en_cnt++;

  custom_axi_regs dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
    .ipreg_data_out_i(ipreg_data_out_i), .enable_i(enable_i), .status_i(status_i)
  );

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got = 0;
    int t = 0;
    resp = 2'bxx;
    bready = 1'b1;
    while (!got && t < 20) begin
      @(negedge clk_i);
      if (bvalid === 1'b1) begin got = 1; resp = bresp; end
      @(posedge clk_i); #1;
      t++;
    end
    bready = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL b_timeout: bvalid not seen within 20 cycles, required bvalid=1");
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int t = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      @(negedge clk_i);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk_i); #1;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      n_chk++; n_fail++;
      resp = 2'bxx;
      $display("FAIL aw_w_timeout: aw=%0b w=%0b accepted, required both", aw_done, w_done);
    end else wait_b(resp);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done = 0, hs;
    int t = 0;
    d = 'x; resp = 'x;
    araddr = a; arvalid = 1'b1;
    while (!done && t < 20) begin
      @(negedge clk_i);
      hs = arready;
      @(posedge clk_i); #1;
      if (hs) begin arvalid = 1'b0; done = 1; end
      t++;
    end
    arvalid = 1'b0;
    done = 0; t = 0;
    rready = 1'b1;
    while (!done && t < 20) begin
      @(negedge clk_i);
      if (rvalid === 1'b1) begin done = 1; d = rdata; resp = rresp; end
      @(posedge clk_i); #1;
      t++;
    end
    rready = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL r_timeout: read of 0x%02h got no rvalid", a);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] a,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d; logic [1:0] r;
    axi_read(a, d, r);
    n_chk++;
    if (d !== exp_d || r !== exp_r) begin
      n_fail++;
      $display("FAIL %s: rdata=%h rresp=%b, required rdata=%h rresp=%b", nm, d, r, exp_d, exp_r);
    end
  endtask

  task automatic chk_wr(input string nm, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(a, d, s, r);
    n_chk++;
    if (r !== exp_r) begin
      n_fail++;
      $display("FAIL %s: bresp=%b, required %b", nm, r, exp_r);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    n_chk++;
    if ({awready, wready, arready, bvalid, rvalid, enable_o} !== 6'b0 ||
        ipreg_data_o !== 32'h0 || rdata !== 32'h0 || bresp !== 2'b0 || rresp !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b%b%b bv=%b rv=%b en=%b data=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, enable_o, ipreg_data_o);
    end
    rst_ni = 1'b1;
    tick();
    n_chk++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_reset: aw/w/ar ready=%b%b%b, required 111", awready, wready, arready);
    end
    chk_rd("read_id", 8'h10, 32'hC0A1_0001, 2'b00);
    chk_rd("read_data_in_reset", 8'h04, 32'h0, 2'b00);
  endtask

  task automatic test_strobe();
    chk_wr("wr_data_in_full", 8'h04, 32'hFFFF_FFFF, 4'hF, 2'b00);
    chk_wr("wr_data_in_strb", 8'h04, 32'h1234_5678, 4'b0011, 2'b00);
    chk_rd("rd_data_in_strb", 8'h04, 32'hFFFF_5678, 2'b00);
    n_chk++;
    if (ipreg_data_o !== 32'hFFFF_5678) begin
      n_fail++;
      $display("FAIL ipreg_data_o: got %h, required ffff5678", ipreg_data_o);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r;
    wdata = 32'hAAAA_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick(); wvalid = 1'b0;
    tick(); tick(); tick();
    awaddr = 8'h04; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    n_chk++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL b_latency_early: bvalid=%b right after AW, required 0", bvalid);
    end
    tick();
    n_chk++;
    if (bvalid !== 1'b1 || ipreg_data_o !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL commit_w_first: bvalid=%b data=%h, required 1/aaaa0001", bvalid, ipreg_data_o);
    end
    // second write gets buffered but must not commit while B is outstanding
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'hBBBB_0002; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    n_chk++;
    if (awready !== 1'b0 || wready !== 1'b0) begin
      n_fail++; $display("FAIL buffers_full: awready=%b wready=%b, required 0/0", awready, wready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (bvalid !== 1'b1 || ipreg_data_o !== 32'hAAAA_0001) begin
        n_fail++;
        $display("FAIL b_hold_%0d: bvalid=%b data=%h, required 1/aaaa0001", i, bvalid, ipreg_data_o);
      end
    end
    chk_rd("rd_while_b_pending", 8'h04, 32'hAAAA_0001, 2'b00);
    wait_b(r);
    n_chk++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL b1_resp: bresp=%b, required 00", r); end
    wait_b(r);
    n_chk++;
    if (r !== 2'b00 || ipreg_data_o !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL second_commit: bresp=%b data=%h, required 00/bbbb0002", r, ipreg_data_o);
    end
  endtask

  task automatic test_start();
    status_i = 2'd0; en_cnt = 0;
    chk_wr("ctrl_start_idle", 8'h00, 32'h1, 4'h1, 2'b00);
    tick(); tick(); tick();
    n_chk++;
    if (en_cnt !== 1) begin n_fail++; $display("FAIL start_pulse: %0d cycles high, required 1", en_cnt); end
    chk_rd("ctrl_reads_0", 8'h00, 32'h0, 2'b00);
    status_i = 2'd1; en_cnt = 0;
    chk_wr("ctrl_start_busy", 8'h00, 32'h1, 4'h1, 2'b00);
    tick(); tick(); tick();
    n_chk++;
    if (en_cnt !== 0) begin n_fail++; $display("FAIL start_busy_pulse: %0d cycles high, required 0", en_cnt); end
    chk_rd("status_rej", 8'h0C, 32'h9, 2'b00);
    chk_wr("w1c_rej", 8'h0C, 32'h8, 4'h1, 2'b00);
    chk_rd("status_rej_clr", 8'h0C, 32'h1, 2'b00);
    status_i = 2'd2; tick(); status_i = 2'd0;
    chk_rd("status_done_sticky", 8'h0C, 32'h4, 2'b00);
    status_i = 2'd2;
    chk_wr("w1c_done_vs_set", 8'h0C, 32'h4, 4'h1, 2'b00);
    chk_rd("status_done_set_wins", 8'h0C, 32'h6, 2'b00);
    status_i = 2'd0;
    chk_wr("w1c_done", 8'h0C, 32'h4, 4'h1, 2'b00);
    chk_rd("status_done_clr", 8'h0C, 32'h0, 2'b00);
    status_i = 2'd3; enable_i = 1'b1;
    chk_rd("status_err_en", 8'h0C, 32'h13, 2'b00);
    status_i = 2'd0; enable_i = 1'b0;
  endtask

  task automatic test_slverr();
    ipreg_data_out_i = 32'hDEAD_BEEF;
    chk_wr("wr_data_out", 8'h08, 32'h1111_1111, 4'hF, 2'b10);
    chk_rd("rd_data_out", 8'h08, 32'hDEAD_BEEF, 2'b00);
    chk_wr("wr_unmapped", 8'h20, 32'h2222_2222, 4'hF, 2'b10);
    chk_rd("rd_unmapped", 8'h20, 32'h0, 2'b10);
    chk_wr("wr_id", 8'h10, 32'h3333_3333, 4'hF, 2'b10);
    chk_rd("rd_id_unchanged", 8'h10, 32'hC0A1_0001, 2'b00);
    n_chk++;
    if (ipreg_data_o !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL slverr_no_effect: data=%h, required bbbb0002", ipreg_data_o);
    end
  endtask

  task automatic test_reset_inflight();
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    tick();
    araddr = 8'h10; arvalid = 1'b1;
    tick(); arvalid = 1'b0;
    n_chk++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL pending_before_rst: bvalid=%b rvalid=%b, required 1/1", bvalid, rvalid);
    end
    rst_ni = 1'b0;
    tick();
    n_chk++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || ipreg_data_o !== 32'h0 || awready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_inflight: bvalid=%b rvalid=%b data=%h awready=%b, required 0/0/0/0",
               bvalid, rvalid, ipreg_data_o, awready);
    end
    rst_ni = 1'b1;
    tick();
    chk_rd("data_in_after_rst", 8'h04, 32'h0, 2'b00);
    chk_rd("status_after_rst", 8'h0C, 32'h0, 2'b00);
  endtask

  initial begin
    rst_ni = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    ipreg_data_out_i = '0; enable_i = 1'b0; status_i = 2'd0;
    test_reset();
    test_strobe();
    test_w_before_aw();
    test_start();
    test_slverr();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
